acc_mul_sequencer: RTL and testbench
====================================

ACC_MUL_SEQUENCER -- requirements
Module: acc_mul_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, data width of the operand, the accumulator and the result.
REQ-002 Parameter CNT_W, default 4, width of the repeat count.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 LoadReq  input  1  direct preload request; sampled only in IDLE with Start=0.
REQ-007 Operand  input  WIDTH  multiplicand, or the preload value.
REQ-008 Count  input  CNT_W  number of additions to perform.
REQ-009 Accum  input  WIDTH  feedback from the accumulator register output B.
REQ-010 AccA  output  WIDTH  drives the accumulator data input A.
REQ-011 Add, Load, Clrn  output  1 each  accumulator controls; Clrn is active-low.
REQ-012 Busy  output  1  operation in progress (CLEAR or ADD).
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 Result  output  WIDTH  registered final accumulator value.
REQ-015 Overflow  output  1  sticky carry-out flag for the current operation.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, ADD and DONE; Add, Load, Clrn, AccA, Busy and Done SHALL be combinational decodes of the state and registers.
REQ-017 Accumulator priority is Add, then Load, then Clrn=0, otherwise load A; to hold, the block SHALL drive Add=0, Load=0, Clrn=1 and AccA=Accum.
REQ-018 In IDLE: hold drive; if Start=1, capture Operand->op_r and Count->cnt_r, clear Overflow, and go to CLEAR.
REQ-019 In IDLE with Start=0 and LoadReq=1: drive Load=1 and AccA=Operand for that cycle only, and stay in IDLE.
REQ-020 In CLEAR: drive Clrn=0, Add=0, Load=0; next state is DONE if cnt_r=0 (Result<=0), else ADD.
REQ-021 In ADD: drive Add=1 and AccA=op_r; decrement cnt_r each cycle; when cnt_r=1, load Result<=Accum+op_r (low WIDTH bits) and go to DONE.
REQ-022 In DONE: hold drive, Done=1; next state is IDLE.
REQ-023 Latency: Start sampled at edge k, Done high during cycle k+Count+2, and Result valid from the same cycle.
REQ-024 Result SHALL hold its value until the next operation completes.
REQ-025 Start or LoadReq outside IDLE (including DONE) SHALL be ignored, with no queuing.
REQ-026 Busy=1 exactly in CLEAR and ADD.
REQ-027 Arithmetic wraps modulo 2^WIDTH, and Result equals (Operand*Count) mod 2^WIDTH.

Reset
REQ-028 RST=1 at a posedge SHALL force IDLE with cnt_r=0, op_r=0, Result=0 and Overflow=0, overriding Start, LoadReq and any in-flight operation.
REQ-029 After reset the outputs SHALL be Add=0, Load=0, Clrn=1, Busy=0, Done=0 and AccA=Accum.
REQ-030 Reset mid-operation SHALL abort with no Done pulse; the accumulator content is left unspecified.

Configuration
REQ-031 With ACC_SEQ_OVERFLOW_EN defined: in ADD, if Accum+op_r carries out of WIDTH bits, Overflow SHALL set on that edge and stay set until the next accepted Start or RST.
REQ-032 Without ACC_SEQ_OVERFLOW_EN: Overflow SHALL be tied to 0 and no carry logic is synthesized; all other behaviour is unchanged.

Verification
REQ-033 Reset, then Start with Operand=5, Count=3 -> CLEAR 1 cycle, ADD 3 cycles, Done in cycle k+5, Result=15, Overflow=0.
REQ-034 Start with Operand=100, Count=3 and the macro defined -> Result=44 and Overflow=1; without the macro -> Result=44 and Overflow=0.
REQ-035 Start with Count=0, Operand=9 -> CLEAR then DONE, Done in cycle k+2, Result=0.
REQ-036 Assert Start again during ADD and in DONE -> ignored; one Done only, Result unchanged by the extra Starts.
REQ-037 LoadReq=1 with Operand=0x3C in IDLE -> Load=1 and AccA=0x3C for one cycle; next cycle hold (AccA=Accum=0x3C).
REQ-038 RST asserted during the 2nd ADD cycle -> IDLE at the next edge, Busy=0, no Done, Result=0, Clrn=1.

Source files
------------

// File: rtl/acc_mul_sequencer_if.sv
// rtl/acc_mul_sequencer_if.sv - request, accumulator-control and result bundle for acc_mul_sequencer
interface acc_mul_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             Start;
    logic             LoadReq;
    logic [WIDTH-1:0] Operand;
    logic [CNT_W-1:0] Count;
    logic [WIDTH-1:0] Accum;
    logic [WIDTH-1:0] AccA;
    logic             Add;
    logic             Load;
    logic             Clrn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Overflow;

    modport master (
        output Start, LoadReq, Operand, Count, Accum,
        input  AccA, Add, Load, Clrn, Busy, Done, Result, Overflow
    );

    modport slave (
        input  Start, LoadReq, Operand, Count, Accum,
        output AccA, Add, Load, Clrn, Busy, Done, Result, Overflow
    );
endinterface

// File: rtl/acc_mul_sequencer.sv
// rtl/acc_mul_sequencer.sv - multiply by repeated addition on an external accumulator
// Optional sticky carry flag enabled by defining ACC_SEQ_OVERFLOW_EN.
module acc_mul_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic              CLK,
    input logic              RST,
    acc_mul_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, ADD, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;

    logic             add_c, load_c, clrn_c, busy_c, done_c;
    logic [WIDTH-1:0] acca_c;

`ifdef ACC_SEQ_OVERFLOW_EN
    logic             ovf_r;
    logic [WIDTH:0]   sum;
    assign sum = {1'b0, bus.Accum} + {1'b0, op_r};
`else
    logic [WIDTH-1:0] sum;
    assign sum = bus.Accum + op_r;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            op_r     <= '0;
            cnt_r    <= '0;
            result_r <= '0;
`ifdef ACC_SEQ_OVERFLOW_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        op_r  <= bus.Operand;
                        cnt_r <= bus.Count;
`ifdef ACC_SEQ_OVERFLOW_EN
                        ovf_r <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    if (cnt_r == '0)
                        result_r <= '0;
                end
                ADD: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    // Accum already holds (n-1)*op here, so this sum is the final product.
                    if (cnt_r == CNT_W'(1))
                        result_r <= sum[WIDTH-1:0];
`ifdef ACC_SEQ_OVERFLOW_EN
                    if (sum[WIDTH])
                        ovf_r <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        add_c   = 1'b0;
        load_c  = 1'b0;
        clrn_c  = 1'b1;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        acca_c  = bus.Accum;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_n = CLEAR;
                end else if (bus.LoadReq) begin
                    load_c = 1'b1;
                    acca_c = bus.Operand;
                end
            end
            CLEAR: begin
                clrn_c  = 1'b0;
                busy_c  = 1'b1;
                state_n = (cnt_r == '0) ? DONE : ADD;
            end
            ADD: begin
                add_c   = 1'b1;
                busy_c  = 1'b1;
                acca_c  = op_r;
                state_n = (cnt_r == CNT_W'(1)) ? DONE : ADD;
            end
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.Add    = add_c;
    assign bus.Load   = load_c;
    assign bus.Clrn   = clrn_c;
    assign bus.Busy   = busy_c;
    assign bus.Done   = done_c;
    assign bus.AccA   = acca_c;
    assign bus.Result = result_r;
`ifdef ACC_SEQ_OVERFLOW_EN
    assign bus.Overflow = ovf_r;
`else
    assign bus.Overflow = 1'b0;
`endif
endmodule

// File: tb/tb_acc_mul_sequencer.sv
// tb/tb_acc_mul_sequencer.sv - randomized and directed bench for acc_mul_sequencer
module tb_acc_mul_sequencer;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int MOD = 1 << W;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [W-1:0] acc = '0;

    acc_mul_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    acc_mul_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    assign bus.Accum = acc;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    bit           ready  = 0;
    bit           active = 0;
    int           rel    = 0;
    int           m_o    = 0;
    int           m_c    = 0;
    logic [W-1:0] m_res  = '0;
    bit           m_ovf  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Running total before the j-th addition is (j-1)*o mod 2^W.
    function automatic bit carry(input int o, input int j);
        return ((((j - 1) * o) % MOD) + o) >= MOD;
    endfunction

    always @(posedge CLK) begin
        if (ready) begin
            if (bus.Add)        acc <= acc + bus.AccA;
            else if (bus.Load)  acc <= bus.AccA;
            else if (!bus.Clrn) acc <= '0;
            else                acc <= bus.AccA;
        end
        if (RST) begin
            ready  = 1;
            active = 0;
            m_res  = '0;
            m_ovf  = 0;
        end else if (active) begin
            if (rel >= 1 && rel <= m_c && carry(m_o, rel)) m_ovf = 1;
            if (rel == m_c) m_res = W'((m_o * m_c) % MOD);
            if (rel == m_c + 1) active = 0;
            rel++;
        end else if (bus.Start) begin
            active = 1;
            rel    = 0;
            m_o    = int'(bus.Operand);
            m_c    = int'(bus.Count);
            m_ovf  = 0;
        end
    end

    always @(negedge CLK) begin
        bit exp_add, exp_load, exp_busy, exp_done, exp_clrn, exp_ovf;
        logic [W-1:0] exp_acca;
        if (ready) begin
            exp_busy = active && rel <= m_c;
            exp_add  = active && rel >= 1 && rel <= m_c;
            exp_done = active && rel == m_c + 1;
            exp_clrn = !(active && rel == 0);
            exp_load = !active && !bus.Start && bus.LoadReq;
            exp_acca = exp_add ? W'(m_o) : (exp_load ? bus.Operand : acc);
`ifdef ACC_SEQ_OVERFLOW_EN
            exp_ovf = m_ovf;
`else
            exp_ovf = 0;
`endif
            check("busy", 32'(bus.Busy), 32'(exp_busy));
            check("add", 32'(bus.Add), 32'(exp_add));
            check("done", 32'(bus.Done), 32'(exp_done));
            check("clrn", 32'(bus.Clrn), 32'(exp_clrn));
            check("load", 32'(bus.Load), 32'(exp_load));
            check("acca", 32'(bus.AccA), 32'(exp_acca));
            check("result", 32'(bus.Result), 32'(m_res));
            check("overflow", 32'(bus.Overflow), 32'(exp_ovf));
        end
    end

    task automatic run_op(input int o, input int c, input int er, input int eo);
        int n;
        @(posedge CLK); #1;
        bus.Start = 1; bus.Operand = W'(o); bus.Count = CW'(c);
        @(posedge CLK); #1;
        bus.Start = 0;
        n = 0;
        @(negedge CLK);
        while (!bus.Done && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("lit_done_latency", 32'(n), 32'(c + 1));
        check("lit_result", 32'(bus.Result), 32'(er));
        check("lit_overflow", 32'(bus.Overflow), 32'(eo));
    endtask

    initial begin
        int dn;
        bus.Start = 0; bus.LoadReq = 0; bus.Operand = '0; bus.Count = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        check("lit_rst_add", 32'(bus.Add), 0);
        check("lit_rst_clrn", 32'(bus.Clrn), 1);
        check("lit_rst_busy", 32'(bus.Busy), 0);
        check("lit_rst_result", 32'(bus.Result), 0);

        run_op(5, 3, 15, 0);
`ifdef ACC_SEQ_OVERFLOW_EN
        run_op(100, 3, 44, 1);
`else
        run_op(100, 3, 44, 0);
`endif
        run_op(9, 0, 0, 0);

        // Extra Starts during ADD and DONE must not queue a second operation.
        @(posedge CLK); #1;
        bus.Start = 1; bus.Operand = 8'd7; bus.Count = 4'd4;
        @(posedge CLK);
        dn = 0;
        for (int r = 0; r <= 5; r++) begin
            #1;
            bus.Start   = (r == 2 || r == 5);
            bus.Operand = bus.Start ? 8'd99 : 8'd7;
            @(negedge CLK);
            if (bus.Done) dn++;
            @(posedge CLK);
        end
        #1 bus.Start = 0;
        @(negedge CLK);
        check("lit_ignore_done_count", 32'(dn), 1);
        check("lit_ignore_result", 32'(bus.Result), 28);
        check("lit_ignore_busy", 32'(bus.Busy), 0);

        @(posedge CLK); #1;
        bus.LoadReq = 1; bus.Operand = 8'h3C;
        @(negedge CLK);
        check("lit_loadreq_load", 32'(bus.Load), 1);
        check("lit_loadreq_acca", 32'(bus.AccA), 32'h3C);
        @(posedge CLK); #1;
        bus.LoadReq = 0;
        @(negedge CLK);
        check("lit_hold_load", 32'(bus.Load), 0);
        check("lit_hold_acca", 32'(bus.AccA), 32'h3C);

        @(posedge CLK); #1;
        bus.Start = 1; bus.Operand = 8'd6; bus.Count = 4'd5;
        @(posedge CLK); #1;
        bus.Start = 0;
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        check("lit_abort_busy", 32'(bus.Busy), 0);
        check("lit_abort_done", 32'(bus.Done), 0);
        check("lit_abort_result", 32'(bus.Result), 0);
        check("lit_abort_clrn", 32'(bus.Clrn), 1);

        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK); #1;
            bus.Start   = ($urandom_range(0, 3) == 0);
            bus.LoadReq = ($urandom_range(0, 2) == 0);
            bus.Operand = W'($urandom);
            bus.Count   = CW'($urandom);
            RST         = ($urandom_range(0, 149) == 0);
        end
        @(posedge CLK); #1;
        bus.Start = 0; bus.LoadReq = 0; RST = 0;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
